// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma serial path: ASCII constants used by the
// output formatter and the formatter FSM state encoding.
package enigma_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP       = 3'd1,
        S_SEP       = 3'd2,
        S_CR        = 3'd3,
        S_LF        = 3'd4,
        S_DATA      = 3'd5,
        S_WAIT_ACK  = 3'd6,
        S_WAIT_DONE = 3'd7
    } fmt_state_e;

    // Upper-case ASCII letter test; only these bytes take part in grouping.
    function automatic logic is_letter(input logic [7:0] b);
        return (b >= ASCII_A) && (b <= ASCII_Z);
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with occupancy count. Writes to a full FIFO and
// reads from an empty FIFO are ignored, so callers may strobe freely.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are meaningless until covered by level.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves level alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                level <= level + (AW + 1)'(1);
            end else if (do_rd && !do_wr) begin
                level <= level - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/tx_group_formatter.sv
// Transmit-side formatter: buffers controller bytes and, when grouping is on,
// splits letter runs into fixed-size groups separated by spaces with CR LF
// after a fixed number of groups. Non-letters pass through untouched.
module tx_group_formatter
    import enigma_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int GROUP_LEN       = 5,
    parameter int GROUPS_PER_LINE = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          group_en,
    input  logic                          flush,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_byte,
    output logic                          tx_start,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(GROUP_LEN + 1);
    localparam int GW = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;
    localparam logic [LW-1:0] LET_MAX  = LW'(GROUP_LEN);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS_PER_LINE - 1);

    fmt_state_e    state;
    fmt_state_e    state_nxt;
    logic [LW-1:0] let_cnt;
    logic [GW-1:0] grp_cnt;
    logic          flush_pend;
    logic          cr_sent;
    logic          pop;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          column_nz;
    logic          flush_done;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_byte),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready  = !fifo_full;
    assign column_nz = (let_cnt != '0) || (grp_cnt != '0);
    // A pending flush retires either when there is nothing to end or once LF goes out.
    assign flush_done = ((state == S_POP) && flush_pend && !column_nz) ||
                        ((state == S_LF) && tx_start);

    // Dropped-write indicator; full is judged before any same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= in_valid && fifo_full;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a write arriving in IDLE already counts as work so
    // the first byte reaches the UART two cycles after its strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty || flush_pend || in_valid || flush) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                if (flush_pend) begin
                    state_nxt = column_nz ? S_CR : S_IDLE;
                end else if (fifo_empty) begin
                    state_nxt = S_IDLE;
                end else if (is_letter(head) && group_en && (let_cnt == LET_MAX)) begin
                    state_nxt = (grp_cnt == GRP_LAST) ? S_CR : S_SEP;
                end else begin
                    state_nxt = S_DATA;
                end
            end
            S_SEP, S_CR, S_LF, S_DATA: begin
                if (!tx_busy) begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (cr_sent) begin
                        state_nxt = S_LF;
                    end else if (!fifo_empty || flush_pend) begin
                        state_nxt = S_POP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: send strobe from any send state once the UART is free; DATA also pops.
    always_comb begin
        tx_start = 1'b0;
        pop      = 1'b0;
        case (state)
            S_SEP, S_CR, S_LF: begin
                tx_start = !tx_busy;
            end
            S_DATA: begin
                tx_start = !tx_busy;
                pop      = !tx_busy;
            end
            default: begin
                tx_start = 1'b0;
                pop      = 1'b0;
            end
        endcase
    end

    // Output byte is latched on entry to a send state so it is stable while sending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte <= 8'h00;
        end else if ((state == S_POP) || (state == S_WAIT_DONE)) begin
            case (state_nxt)
                S_SEP:   tx_byte <= ASCII_SPACE;
                S_CR:    tx_byte <= ASCII_CR;
                S_LF:    tx_byte <= ASCII_LF;
                S_DATA:  tx_byte <= head;
                default: tx_byte <= tx_byte;
            endcase
        end
    end

    // Column tracking and flush bookkeeping, updated as each byte is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            let_cnt    <= '0;
            grp_cnt    <= '0;
            flush_pend <= 1'b0;
            cr_sent    <= 1'b0;
        end else begin
            if (flush) begin
                flush_pend <= 1'b1;
            end else if (flush_done) begin
                flush_pend <= 1'b0;
            end
            if (tx_start) begin
                cr_sent <= (state == S_CR);
                case (state)
                    S_SEP: begin
                        let_cnt <= '0;
                        grp_cnt <= grp_cnt + GW'(1);
                    end
                    S_LF: begin
                        let_cnt <= '0;
                        grp_cnt <= '0;
                    end
                    S_DATA: begin
                        if (is_letter(tx_byte)) begin
                            if (let_cnt != LET_MAX) begin
                                let_cnt <= let_cnt + LW'(1);
                            end
                        end else if ((tx_byte == ASCII_CR) || (tx_byte == ASCII_LF)) begin
                            let_cnt <= '0;
                            grp_cnt <= '0;
                        end
                    end
                    default: begin
                        let_cnt <= let_cnt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_group_formatter.sv
// Scoreboard bench for tx_group_formatter: a byte-level reference model turns
// each written byte (and each flush) into the UART bytes it should produce.
module tb_tx_group_formatter;
    localparam int DEPTH = 16;
    localparam int GLEN  = 5;
    localparam int GPL   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       group_en = 1'b1;
    logic       flush = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       overflow;
    logic [4:0] fifo_level;

    logic       hold_busy = 1'b0;
    logic [3:0] busy_cnt;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q[$];
    int m_let = 0;
    int m_grp = 0;

    tx_group_formatter #(
        .FIFO_DEPTH      (DEPTH),
        .GROUP_LEN       (GLEN),
        .GROUPS_PER_LINE (GPL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .group_en   (group_en),
        .flush      (flush),
        .tx_busy    (tx_busy),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Simple UART stand-in: busy for a random number of cycles after each start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 4'd0;
        else if (tx_start) busy_cnt <= 4'($urandom_range(1, 8));
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign tx_busy = hold_busy || (busy_cnt != 4'd0);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: what the UART should see for one byte written.
    function automatic void model_byte(input logic [7:0] b, input logic ge);
        bit letter;
        letter = (b >= 8'h41) && (b <= 8'h5A);
        if (letter && ge && m_let == GLEN) begin
            if (m_grp == GPL - 1) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                m_grp = 0;
            end else begin
                exp_q.push_back(8'h20);
                m_grp++;
            end
            m_let = 0;
        end
        exp_q.push_back(b);
        if (letter) begin
            if (m_let < GLEN) m_let++;
        end else if (b == 8'h0D || b == 8'h0A) begin
            m_let = 0;
            m_grp = 0;
        end
    endfunction

    function automatic void model_flush();
        if (m_let != 0 || m_grp != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_let = 0;
            m_grp = 0;
        end
    endfunction

    // Monitor: every send strobe is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && overflow) ovf_cnt++;
        if (rst_n && tx_start) begin
            check("start_while_busy", 32'(tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte got %0h expected none", tx_byte);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_byte  = b;
        in_valid = 1'b1;
        model_byte(b, group_en);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_letters(input string s);
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        idle(20);
        check("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_before;
        logic [7:0] b;
        int r;
        bit ok;

        // Reset values
        idle(3);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Grouping with a line break after GPL groups, then flush behaviour
        group_en = 1'b1;
        push_letters("ABCDEFGHIJKL");
        drain();
        pulse_flush();
        drain();
        push_letters("ABC");
        drain();
        pulse_flush();
        drain();
        pulse_flush();
        idle(30);
        check("flush_col0_quiet", 32'(exp_q.size()), 32'd0);

        // Latency from an idle, empty formatter
        push_byte(8'h51);
        check("latency_cycle1", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        check("latency_cycle2", 32'(tx_start), 32'd1);
        drain();
        pulse_flush();
        drain();

        // Pass-through: line ending resets the column, letters saturate
        group_en = 1'b0;
        push_letters("OK");
        push_byte(8'h0D);
        push_byte(8'h0A);
        push_letters("ABCDEFG");
        drain();
        group_en = 1'b1;
        push_letters("HI");
        drain();

        // Overflow with the UART held busy
        group_en  = 1'b0;
        hold_busy = 1'b1;
        ovf_before = ovf_cnt;
        for (int i = 0; i < DEPTH + 1; i++) begin
            ok       = in_ready;
            b        = 8'h30 + 8'(i % 10);
            in_byte  = b;
            in_valid = 1'b1;
            if (ok) model_byte(b, group_en);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'(DEPTH));
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        idle(1);
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        check("ovf_count", 32'(ovf_cnt - ovf_before), 32'd1);
        hold_busy = 1'b0;
        drain();

        // Randomized phases
        for (int ph = 0; ph < 6; ph++) begin
            group_en = 1'($urandom_range(0, 1));
            for (int k = 0; k < 30; k++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      b = 8'h41 + 8'($urandom_range(0, 25));
                else if (r < 80) b = 8'h30 + 8'($urandom_range(0, 9));
                else if (r < 85) b = 8'h20;
                else if (r < 90) b = 8'h0D;
                else if (r < 95) b = 8'h0A;
                else             b = 8'h2E;
                push_byte(b);
                idle($urandom_range(0, 3));
            end
            drain();
            if ($urandom_range(0, 1) == 1) begin
                pulse_flush();
                drain();
            end
        end

        // Reset in the middle of a send
        group_en = 1'b1;
        push_letters("ABCDEFGH");
        r = 0;
        @(negedge clk);
        while (!tx_start && r < 200) begin
            @(negedge clk);
            r++;
        end
        check("midrst_saw_start", 32'(tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_start_drop", 32'(tx_start), 32'd0);
        exp_q.delete();
        m_let = 0;
        m_grp = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        push_letters("ABCDEFG");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
